// File: rtl/uart_to_parallel.sv
// 8N1 UART receiver: oversampled, re-aligned on every start edge, LSB-first bytes out
// with a one-cycle valid strobe and a one-cycle framing-error strobe on a low stop bit.
module uart_to_parallel #(
    parameter int input_clock_frequency = 100000,
    parameter int baud_rate             = 115200,
    parameter int oversample            = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int TICK_DIV = (input_clock_frequency * 1000) / (baud_rate * oversample);
    localparam int TCW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCW      = $clog2(oversample);

    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
    localparam logic [SCW-1:0] HALF_LAST = SCW'(oversample / 2 - 1);
    localparam logic [SCW-1:0] FULL_LAST = SCW'(oversample - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t         state_q, state_d;
    logic           sync1_q, rx_s_q;
    logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
    logic [SCW-1:0] samp_cnt_q, samp_cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           ferr_q, ferr_d;
    logic           tick;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        samp_cnt_d = samp_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                samp_cnt_d = '0;
                bit_idx_d  = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + TCW'(1);
                if (tick) begin
                    samp_cnt_d = samp_cnt_q + SCW'(1);
                    // Mid start bit: a line already back high was only a glitch.
                    if (samp_cnt_q == HALF_LAST) begin
                        samp_cnt_d = '0;
                        bit_idx_d  = '0;
                        state_d    = rx_s_q ? S_IDLE : S_DATA;
                    end
                end
            end
            S_DATA: begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + TCW'(1);
                if (tick) begin
                    samp_cnt_d = samp_cnt_q + SCW'(1);
                    if (samp_cnt_q == FULL_LAST) begin
                        samp_cnt_d = '0;
                        shift_d    = {rx_s_q, shift_q[7:1]};
                        bit_idx_d  = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + TCW'(1);
                if (tick) begin
                    samp_cnt_d = samp_cnt_q + SCW'(1);
                    if (samp_cnt_q == FULL_LAST) begin
                        samp_cnt_d = '0;
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_WAIT_IDLE;
                        end
                    end
                end
            end
            S_WAIT_IDLE: begin
                // A held-low line (break) reports one error, then waits for idle.
                tick_cnt_d = '0;
                samp_cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            samp_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync1_q    <= serial_in;
            rx_s_q     <= sync1_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    assign data          = data_q;
    assign data_valid    = valid_q;
    assign framing_error = ferr_q;
    assign busy          = (state_q != S_IDLE);

endmodule
